bk_kbd_ctrl: RTL
================

BK_KBD_CTRL -- requirements
Module: bk_kbd_ctrl

Interface
REQ-001 SHALL have port clk_sys, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port scan_valid, input, 1 bit: one-cycle strobe qualifying scan_code.
REQ-004 SHALL have port scan_code, input, 8 bits: raw PS/2 set-2 byte from the deserializer.
REQ-005 SHALL have port cpu_rd, input, 1 bit: one-cycle strobe for a CPU read of the keyboard data register.
REQ-006 SHALL have port irq_en, input, 1 bit: keyboard interrupt enable (inverse of status register bit 6).
REQ-007 SHALL have port key_ready, output, 1 bit: new code pending (status register bit 7).
REQ-008 SHALL have port key_code, output, 7 bits: latched BK key code (data register).
REQ-009 SHALL have port key_ar2, output, 1 bit: latched code uses the AR2 (vector 274) interrupt.
REQ-010 SHALL have port key_down, output, 1 bit: a code-producing key is physically held.
REQ-011 SHALL have port irq, output, 1 bit: keyboard interrupt request.

Function
REQ-012 SHALL decode the prefix with FSM states IDLE, EXT (after E0), BRK (after F0), EXTBRK (after E0 F0) and SKIP.
REQ-013 SHALL use these transitions: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXTBRK; E1 in any state->SKIP with skip counter=7.
REQ-014 SHALL, in SKIP, decrement the counter on each strobe, return to IDLE at 0, and produce no code, so that Pause is swallowed.
REQ-015 SHALL, on any other byte, treat it as make (IDLE/EXT) or break (BRK/EXTBRK), carry e0=1 for EXT/EXTBRK, and return to IDLE.
REQ-016 SHALL update the shift state as follows: make/break of 12 or 59 without e0 sets/clears lshift/rshift; shift=lshift|rshift. E0 12 and E0 59 are ignored.
REQ-017 SHALL, on a make, present {shift, e0, byte} to the translator; a nonzero result is loaded in the same cycle as a key event.
REQ-018 SHALL, for a key event: if key_ready=0, load key_code=result[6:0] and key_ar2=result[7], set key_ready=1, set key_down=1, and store the byte as held_scan.
REQ-019 SHALL, for a key event when key_ready=1 and no cpu_rd in that cycle, drop the code and leave key_code unchanged (no overwrite); key_down and held_scan still update.
REQ-020 SHALL clear key_ready on cpu_rd; if cpu_rd and a key event coincide, the load wins: the new code is latched and key_ready stays 1.
REQ-021 SHALL clear key_down on a break whose byte equals held_scan; a break of any other byte leaves key_down unchanged.
REQ-022 SHALL drive irq = key_ready & irq_en combinationally (level, no pulse stretching).
REQ-023 SHALL accept strobes on back-to-back cycles; latency from scan_valid to key_ready is 1 clk_sys cycle.

Reset
REQ-024 SHALL, on reset assertion, immediately set: FSM=IDLE, skip counter=0, lshift=rshift=0, key_ready=0, key_code=0, key_ar2=0, key_down=0, held_scan=0; irq follows as 0.
REQ-025 SHALL, on reset mid-sequence (e.g. after E0 or inside SKIP), discard the partial prefix; the next byte decodes from IDLE.

Configuration
REQ-026 SHALL support macro KBD_TYPEMATIC_EN: when defined, a make equal to held_scan with key_down=1 (typematic repeat) is a normal key event.
REQ-027 SHALL, when KBD_TYPEMATIC_EN is undefined, ignore such repeats entirely; only the first make per press yields a code.

Structure
REQ-028 SHALL take from the shared package bk_kbd_pkg: the FSM state encoding, constants SC_E0=E0, SC_F0=F0, SC_E1=E1, SC_LSHIFT=12, SC_RSHIFT=59, and PAUSE_SKIP=7.
REQ-029 SHALL instantiate exactly one sub-module, kbd_transl (scancode-to-BK-code translator), driven by the registered shift, the decoded e0 and the current byte.

Verification
REQ-030 SHALL pass: strobe 1C -> next cycle key_ready=1, key_code=61h, key_ar2=0; cpu_rd -> key_ready=0.
REQ-031 SHALL pass: 12, 1C, F0 1C, F0 12 -> key_code=41h; key_down 1 then 0; shift cleared.
REQ-032 SHALL pass: 05 (F1) -> key_code=01h, key_ar2=1; with irq_en=1, irq=1 until cpu_rd.
REQ-033 SHALL pass: 1C then 32 without cpu_rd -> key_code stays 61h; 32 with coincident cpu_rd -> key_code=62h, key_ready=1.
REQ-034 SHALL pass: E1 14 77 E1 F0 14 F0 77 then 1C -> only 61h produced; E0 12 leaves shift=0.
REQ-035 SHALL pass: 1C 1C 1C held -> three codes with KBD_TYPEMATIC_EN, one without; reset asserted after E0 -> next 1C decodes as 61h.

Source files
------------

// File: rtl/bk_kbd_pkg.sv
// Shared definitions for the BK keyboard controller: prefix FSM encoding,
// PS/2 set-2 prefix/shift constants and the shift-case helper.
package bk_kbd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EXT    = 3'd1,
      ST_BRK    = 3'd2,
      ST_EXTBRK = 3'd3,
      ST_SKIP   = 3'd4
   } kbd_state_t;

   localparam logic [7:0] SC_E0      = 8'hE0;
   localparam logic [7:0] SC_F0      = 8'hF0;
   localparam logic [7:0] SC_E1      = 8'hE1;
   localparam logic [7:0] SC_LSHIFT  = 8'h12;
   localparam logic [7:0] SC_RSHIFT  = 8'h59;
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   // Letters go upper case, digits 1..9 go to their punctuation partners.
   function automatic logic [6:0] apply_shift(input logic [6:0] base, input logic shift);
      logic [6:0] res;
      if (shift && (base >= 7'h61) && (base <= 7'h7A)) begin
         res = base - 7'h20;
      end else if (shift && (base >= 7'h31) && (base <= 7'h39)) begin
         res = base ^ 7'h10;
      end else begin
         res = base;
      end
      return res;
   endfunction

endpackage

// File: rtl/bk_kbd_ctrl_transl.sv
// Scancode-to-BK-code translator: combinational lookup of {shift, e0, byte};
// result bit 7 selects the AR2 interrupt vector, zero means no code.
module kbd_transl
   import bk_kbd_pkg::*;
(
   input  logic       shift,
   input  logic       e0,
   input  logic [7:0] scan,
   output logic [7:0] code
);

   logic [6:0] base_s;
   logic       ar2_s;

   // Unshifted base code per key
   always_comb begin
      base_s = 7'h00;
      ar2_s  = 1'b0;
      if (e0) begin
         case (scan)
            8'h75:   base_s = 7'h1A;
            8'h72:   base_s = 7'h1B;
            8'h6B:   base_s = 7'h08;
            8'h74:   base_s = 7'h19;
            default: base_s = 7'h00;
         endcase
      end else begin
         case (scan)
            8'h1C: base_s = 7'h61;  8'h32: base_s = 7'h62;  8'h21: base_s = 7'h63;
            8'h23: base_s = 7'h64;  8'h24: base_s = 7'h65;  8'h2B: base_s = 7'h66;
            8'h34: base_s = 7'h67;  8'h33: base_s = 7'h68;  8'h43: base_s = 7'h69;
            8'h3B: base_s = 7'h6A;  8'h42: base_s = 7'h6B;  8'h4B: base_s = 7'h6C;
            8'h3A: base_s = 7'h6D;  8'h31: base_s = 7'h6E;  8'h44: base_s = 7'h6F;
            8'h4D: base_s = 7'h70;  8'h15: base_s = 7'h71;  8'h2D: base_s = 7'h72;
            8'h1B: base_s = 7'h73;  8'h2C: base_s = 7'h74;  8'h3C: base_s = 7'h75;
            8'h2A: base_s = 7'h76;  8'h1D: base_s = 7'h77;  8'h22: base_s = 7'h78;
            8'h35: base_s = 7'h79;  8'h1A: base_s = 7'h7A;
            8'h16: base_s = 7'h31;  8'h1E: base_s = 7'h32;  8'h26: base_s = 7'h33;
            8'h25: base_s = 7'h34;  8'h2E: base_s = 7'h35;  8'h36: base_s = 7'h36;
            8'h3D: base_s = 7'h37;  8'h3E: base_s = 7'h38;  8'h46: base_s = 7'h39;
            8'h45: base_s = 7'h30;
            8'h29: base_s = 7'h20;  8'h5A: base_s = 7'h0A;  8'h66: base_s = 7'h18;
            8'h0D: base_s = 7'h09;
            // function keys raise the AR2 interrupt instead of the normal one
            8'h05: begin base_s = 7'h01; ar2_s = 1'b1; end
            8'h06: begin base_s = 7'h02; ar2_s = 1'b1; end
            default: base_s = 7'h00;
         endcase
      end
   end

   assign code = {ar2_s, apply_shift(base_s, shift)};

endmodule

// File: rtl/bk_kbd_ctrl.sv
// BK keyboard controller: PS/2 set-2 prefix decode, shift tracking and the
// key data/status registers. Build macro KBD_TYPEMATIC_EN accepts typematic repeats.
module bk_kbd_ctrl
   import bk_kbd_pkg::*;
(
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       scan_valid,
   input  logic [7:0] scan_code,
   input  logic       cpu_rd,
   input  logic       irq_en,
   output logic       key_ready,
   output logic [6:0] key_code,
   output logic       key_ar2,
   output logic       key_down,
   output logic       irq
);

   kbd_state_t state_r;
   logic [2:0] skip_r;
   logic       lshift_r, rshift_r;
   logic [7:0] held_r;
   logic       ready_r, ar2_r, down_r;
   logic [6:0] code_r;
   logic       e0_s, shift_s, make_s, brk_s, key_evt_s, load_s;
   logic [7:0] transl_s;

   assign e0_s    = (state_r == ST_EXT) || (state_r == ST_EXTBRK);
   assign shift_s = lshift_r | rshift_r;

   kbd_transl u_transl (
      .shift (shift_s),
      .e0    (e0_s),
      .scan  (scan_code),
      .code  (transl_s)
   );

   // Classify the current strobe as a make or break of a real key byte
   always_comb begin
      make_s = 1'b0;
      brk_s  = 1'b0;
      if (scan_valid && (scan_code != SC_E1)) begin
         case (state_r)
            ST_IDLE:   make_s = (scan_code != SC_E0) && (scan_code != SC_F0);
            ST_EXT:    make_s = (scan_code != SC_F0);
            ST_BRK,
            ST_EXTBRK: brk_s = 1'b1;
            default: begin
               make_s = 1'b0;
               brk_s  = 1'b0;
            end
         endcase
      end else begin
         make_s = 1'b0;
         brk_s  = 1'b0;
      end
   end

`ifdef KBD_TYPEMATIC_EN
   assign key_evt_s = make_s && (transl_s != 8'h00);
`else
   assign key_evt_s = make_s && (transl_s != 8'h00) && !(down_r && (scan_code == held_r));
`endif
   // a coincident CPU read frees the register, so the new code is not lost
   assign load_s = key_evt_s && (!ready_r || cpu_rd);

   // Prefix decoder FSM; Pause (E1 ...) is swallowed by the skip counter
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         skip_r  <= 3'd0;
      end else if (scan_valid) begin
         case (state_r)
            ST_SKIP: begin
               if (skip_r <= 3'd1) begin
                  skip_r  <= 3'd0;
                  state_r <= ST_IDLE;
               end else begin
                  skip_r  <= skip_r - 3'd1;
               end
            end
            default: begin
               if (scan_code == SC_E1) begin
                  state_r <= ST_SKIP;
                  skip_r  <= PAUSE_SKIP;
               end else if ((state_r == ST_IDLE) && (scan_code == SC_E0)) begin
                  state_r <= ST_EXT;
               end else if ((state_r == ST_IDLE) && (scan_code == SC_F0)) begin
                  state_r <= ST_BRK;
               end else if ((state_r == ST_EXT) && (scan_code == SC_F0)) begin
                  state_r <= ST_EXTBRK;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Shift tracking and the key data/status registers
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         lshift_r <= 1'b0;
         rshift_r <= 1'b0;
         held_r   <= 8'h00;
         ready_r  <= 1'b0;
         code_r   <= 7'h00;
         ar2_r    <= 1'b0;
         down_r   <= 1'b0;
      end else begin
         if (!e0_s && (scan_code == SC_LSHIFT) && (make_s || brk_s)) begin
            lshift_r <= make_s;
         end
         if (!e0_s && (scan_code == SC_RSHIFT) && (make_s || brk_s)) begin
            rshift_r <= make_s;
         end
         if (load_s) begin
            code_r  <= transl_s[6:0];
            ar2_r   <= transl_s[7];
            ready_r <= 1'b1;
         end else if (cpu_rd) begin
            ready_r <= 1'b0;
         end
         if (key_evt_s) begin
            down_r <= 1'b1;
            held_r <= scan_code;
         end else if (brk_s && (scan_code == held_r)) begin
            down_r <= 1'b0;
         end
      end
   end

   assign key_ready = ready_r;
   assign key_code  = code_r;
   assign key_ar2   = ar2_r;
   assign key_down  = down_r;
   assign irq       = ready_r & irq_en;

endmodule
